// File: rtl/counter_ctrl.sv
// Run/pause/clear controller producing the 4-bit digit for the 7-segment decoder.
// Optional start-button synchroniser and debouncer enabled by COUNTER_DEBOUNCE_EN.
module counter_ctrl #(
  parameter int DIV_MAX = 5_000_000,
  parameter int PRESC_W = 23,
  parameter int DB_CYC  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_clear,
  input  logic       i_dir,
  input  logic       i_dec,
  output logic [3:0] o_num,
  output logic       o_carry,
  output logic       o_run
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV_MAX - 1);

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic               start_lvl;
  logic               st_q;
  logic               start_edge;
  logic               tick;

`ifdef COUNTER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic            sync1;
  logic            sync2;
  logic            clean;
  logic [DB_W-1:0] db_cnt;

  // The clean level follows sync2 only after DB_CYC consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      clean  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= i_start;
      sync2 <= sync1;
      if (sync2 == clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        clean  <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign start_lvl = clean;
`else
  assign start_lvl = i_start;
`endif

  assign start_edge = start_lvl & ~st_q;
  assign tick       = (state == RUN) && (presc == PRESC_LAST);

  // Returns {carry, next digit}. An out-of-range decimal digit snaps to 0 going up, 9 going down.
  function automatic logic [4:0] step_num(input logic [3:0] num, input logic dir, input logic dec);
    logic [3:0] top;
    top = dec ? 4'd9 : 4'd15;
    if (!dir) begin
      if (num >= top) step_num = 5'b1_0000;
      else            step_num = {1'b0, num + 4'd1};
    end else begin
      if (num == 4'd0)     step_num = {1'b1, top};
      else if (num > top)  step_num = {1'b0, 4'd9};
      else                 step_num = {1'b0, num - 4'd1};
    end
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      st_q    <= 1'b0;
      o_num   <= 4'd0;
      o_carry <= 1'b0;
      o_run   <= 1'b0;
    end else begin
      st_q    <= start_lvl;
      o_carry <= 1'b0;
      if (i_clear) begin
        state <= IDLE;
        presc <= '0;
        o_num <= 4'd0;
        o_run <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (start_edge) begin
              state <= RUN;
              o_run <= 1'b1;
            end
          end
          RUN: begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) {o_carry, o_num} <= step_num(o_num, i_dir, i_dec);
            if (start_edge) begin
              state <= PAUSE;
              o_run <= 1'b0;
            end
          end
          PAUSE: begin
            if (start_edge) begin
              state <= RUN;
              o_run <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            o_run <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with DIV_MAX=4, default build (no debounce).
module tb_counter_ctrl;

  localparam int DIV_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic       dir;
  logic       dec;
  logic [3:0] num;
  logic       carry;
  logic       run;

  int total = 0;
  int bad   = 0;

  counter_ctrl #(.DIV_MAX(DIV_MAX), .PRESC_W(23), .DB_CYC(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_clear(clear),
    .i_dir  (dir),
    .i_dec  (dec),
    .o_num  (num),
    .o_carry(carry),
    .o_run  (run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  // Called at the negedge just after a step edge; checks the digit holds then steps.
  task automatic do_step(input string tag, input int prev, input int exp, input int expc);
    cyc(DIV_MAX - 1);
    chk({tag, "_hold"}, 32'(num), 32'(prev));
    chk({tag, "_nocarry"}, 32'(carry), 0);
    cyc(1);
    chk({tag, "_num"}, 32'(num), 32'(exp));
    chk({tag, "_carry"}, 32'(carry), 32'(expc));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    dir   = 1'b0;
    dec   = 1'b0;

    // 1: async reset before the first edge, then idle with no start
    #2 rst_n = 1'b0;
    #1;
    chk("rst_num", 32'(num), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_run", 32'(run), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_num", 32'(num), 0);
    chk("idle_run", 32'(run), 0);
    chk("idle_carry", 32'(carry), 0);

    // 2: hex up full cycle, carry on 15->0
    pulse_start();
    chk("hex_run", 32'(run), 1);
    chk("hex_num0", 32'(num), 0);
    for (int k = 1; k <= 16; k++) begin
      do_step("hex", k - 1, k % 16, (k == 16) ? 1 : 0);
    end
    cyc(1);
    chk("hex_carry_drop", 32'(carry), 0);
    cyc(DIV_MAX - 1);
    chk("hex_after_wrap", 32'(num), 1);

    // 3: decimal up, down wrap, and decimal snap from 12 going down
    pulse_clear();
    chk("clr3_num", 32'(num), 0);
    chk("clr3_run", 32'(run), 0);
    dec = 1'b1;
    pulse_start();
    for (int k = 1; k <= 10; k++) begin
      do_step("decup", k - 1, k % 10, (k == 10) ? 1 : 0);
    end
    dir = 1'b1;
    do_step("decdn_wrap", 0, 9, 1);
    do_step("decdn", 9, 8, 0);
    dec = 1'b0;
    dir = 1'b0;
    for (int k = 9; k <= 12; k++) begin
      do_step("hexup12", k - 1, k, 0);
    end
    dir = 1'b1;
    dec = 1'b1;
    do_step("dec_snap", 12, 9, 0);
    do_step("dec_snap_next", 9, 8, 0);

    // 4: pause one cycle after a step at 5, resume finishes the remaining period
    pulse_clear();
    dir = 1'b0;
    dec = 1'b0;
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      do_step("pre_pause", k - 1, k, 0);
    end
    pulse_start();
    chk("pause_run", 32'(run), 0);
    cyc(30);
    chk("pause_num", 32'(num), 5);
    chk("pause_run_hold", 32'(run), 0);
    pulse_start();
    chk("resume_run", 32'(run), 1);
    cyc(2);
    chk("resume_hold", 32'(num), 5);
    cyc(1);
    chk("resume_step", 32'(num), 6);

    // 5: clear in RUN at 7, then clear together with a start edge
    do_step("to7", 6, 7, 0);
    pulse_clear();
    chk("clr_num", 32'(num), 0);
    chk("clr_run", 32'(run), 0);
    clear = 1'b1;
    start = 1'b1;
    cyc(1);
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_run", 32'(run), 0);
    chk("clr_start_num", 32'(num), 0);
    cyc(10);
    chk("clr_start_stay", 32'(run), 0);
    pulse_start();
    chk("restart_run", 32'(run), 1);
    do_step("restart", 0, 1, 0);

    // async reset mid-run, then no restart without a new start edge
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_num", 32'(num), 0);
    chk("midrst_run", 32'(run), 0);
    chk("midrst_carry", 32'(carry), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    chk("postrst_run", 32'(run), 0);
    chk("postrst_num", 32'(num), 0);
    pulse_start();
    do_step("postrst", 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
